// File: rtl/rx_link_ctrl.sv
// SERDES receive link supervisor: hunts for commas, declares lock, tracks error
// level while locked, and pulses the receiver reset to force realignment.
module rx_link_ctrl #(
  parameter int unsigned LOCK_COMMAS  = 3,
  parameter int unsigned MAX_ERR      = 4,
  parameter int unsigned GOOD_WIN     = 16,
  parameter int unsigned HUNT_TIMEOUT = 1023,
  parameter int unsigned REALIGN_CYC  = 8,
  parameter int unsigned ERRCNT_W     = 16
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                symValid,
  input  logic                comma,
  input  logic                err,
  output logic                rxResetN,
  output logic                linkUp,
  output logic [2:0]          state,
  output logic [ERRCNT_W-1:0] errTotal,
  output logic [7:0]          realignCount
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    HUNT     = 3'd1,
    ACQ      = 3'd2,
    LOCKED   = 3'd3,
    DEGRADED = 3'd4,
    REALIGN  = 3'd5
  } state_e;

  // One timer serves both the HUNT+ACQ timeout and the REALIGN hold.
  localparam int unsigned TMAX = (HUNT_TIMEOUT > REALIGN_CYC) ? HUNT_TIMEOUT : REALIGN_CYC;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [TW-1:0] HUNT_LAST = TW'(HUNT_TIMEOUT - 1);
  localparam logic [TW-1:0] RA_LAST   = TW'(REALIGN_CYC - 1);
  localparam logic [3:0]    LOCK_N    = 4'(LOCK_COMMAS);
  localparam logic [3:0]    MAXE_N    = 4'(MAX_ERR);
  localparam logic [7:0]    GOOD_N    = 8'(GOOD_WIN);

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           commaCnt_q, commaCnt_d;
  logic [3:0]           errLevel_q, errLevel_d;
  logic [7:0]           goodCnt_q, goodCnt_d;
  logic [ERRCNT_W-1:0]  errTotal_q, errTotal_d;
  logic [7:0]           realignCount_q, realignCount_d;
  logic                 rxResetN_q, rxResetN_d;
  logic                 linkUp_q, linkUp_d;

  logic                 good_sym, bad_sym, good_comma, go_realign;
  logic [ERRCNT_W-1:0]  errTotal_inc;

  // err dominates comma on the same symbol
  assign good_sym     = symValid & ~err;
  assign bad_sym      = symValid & err;
  assign good_comma   = good_sym & comma;
  assign errTotal_inc = (errTotal_q == '1) ? errTotal_q : errTotal_q + ERRCNT_W'(1);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    commaCnt_d     = commaCnt_q;
    errLevel_d     = errLevel_q;
    goodCnt_d      = goodCnt_q;
    errTotal_d     = errTotal_q;
    realignCount_d = realignCount_q;
    go_realign     = 1'b0;

    if (!enable) begin
      state_d    = DISABLED;
      timer_d    = '0;
      commaCnt_d = '0;
      errLevel_d = '0;
      goodCnt_d  = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d = HUNT;
          timer_d = '0;
        end
        HUNT: begin
          if (timer_q == HUNT_LAST) begin
            go_realign = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
            if (good_comma) begin
              state_d    = ACQ;
              commaCnt_d = 4'd1;
            end
          end
        end
        ACQ: begin
          if (bad_sym) begin
            errTotal_d = errTotal_inc;
            go_realign = 1'b1;
          end else if (timer_q == HUNT_LAST) begin
            go_realign = 1'b1;
          end else if (good_comma && (commaCnt_q + 4'd1 == LOCK_N)) begin
            state_d    = LOCKED;
            timer_d    = '0;
            commaCnt_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
            if (good_comma) commaCnt_d = commaCnt_q + 4'd1;
          end
        end
        LOCKED: begin
          if (bad_sym) begin
            state_d    = DEGRADED;
            errLevel_d = 4'd1;
            goodCnt_d  = '0;
            errTotal_d = errTotal_inc;
          end
        end
        DEGRADED: begin
          if (bad_sym) begin
            errTotal_d = errTotal_inc;
            goodCnt_d  = '0;
            if (errLevel_q + 4'd1 == MAXE_N) go_realign = 1'b1;
            else                             errLevel_d = errLevel_q + 4'd1;
          end else if (good_sym) begin
            if (goodCnt_q + 8'd1 == GOOD_N) begin
              goodCnt_d  = '0;
              errLevel_d = errLevel_q - 4'd1;
              if (errLevel_q == 4'd1) state_d = LOCKED;
            end else begin
              goodCnt_d = goodCnt_q + 8'd1;
            end
          end
        end
        REALIGN: begin
          if (timer_q == RA_LAST) begin
            state_d    = HUNT;
            timer_d    = '0;
            commaCnt_d = '0;
            errLevel_d = '0;
            goodCnt_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d    = DISABLED;
          timer_d    = '0;
          commaCnt_d = '0;
          errLevel_d = '0;
          goodCnt_d  = '0;
        end
      endcase

      if (go_realign) begin
        state_d    = REALIGN;
        timer_d    = '0;
        commaCnt_d = '0;
        errLevel_d = '0;
        goodCnt_d  = '0;
        if (realignCount_q != '1) realignCount_d = realignCount_q + 8'd1;
      end
    end

    // Outputs registered from the next state so they change on the same edge
    rxResetN_d = (state_d == HUNT) || (state_d == ACQ) ||
                 (state_d == LOCKED) || (state_d == DEGRADED);
    linkUp_d   = (state_d == LOCKED) || (state_d == DEGRADED);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= DISABLED;
      timer_q        <= '0;
      commaCnt_q     <= '0;
      errLevel_q     <= '0;
      goodCnt_q      <= '0;
      errTotal_q     <= '0;
      realignCount_q <= '0;
      rxResetN_q     <= 1'b0;
      linkUp_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      commaCnt_q     <= commaCnt_d;
      errLevel_q     <= errLevel_d;
      goodCnt_q      <= goodCnt_d;
      errTotal_q     <= errTotal_d;
      realignCount_q <= realignCount_d;
      rxResetN_q     <= rxResetN_d;
      linkUp_q       <= linkUp_d;
    end
  end

  assign state        = state_q;
  assign rxResetN     = rxResetN_q;
  assign linkUp       = linkUp_q;
  assign errTotal     = errTotal_q;
  assign realignCount = realignCount_q;

endmodule

// File: doc/rx_link_ctrl.md
Name: rx_link_ctrl

Overview:
Link-supervision controller for the SERDES receiver.
- Sequences the receiver through disable, comma hunt, acquisition, lock, degraded and realign phases.
- Drives the receiver's active-low reset to force re-synchronisation.
- Consumes the receiver's per-symbol strobe, comma and error flags; reports link status and error statistics to the top level.

Parameters:
LOCK_COMMAS, 3, consecutive error-free commas needed in ACQ to declare lock (2..15)
MAX_ERR, 4, error level in DEGRADED that forces REALIGN (2..15)
GOOD_WIN, 16, consecutive good symbols that decrement the error level by 1 (2..255)
HUNT_TIMEOUT, 1023, clk cycles allowed in HUNT+ACQ before forcing REALIGN (>=2)
REALIGN_CYC, 8, clk cycles rxResetN is held low in REALIGN (>=1)
ERRCNT_W, 16, width of the errTotal counter

Ports:
clk  input  1  system clock; all logic on rising edge
resetN  input  1  synchronous active-low reset
enable  input  1  link enable from top level
symValid  input  1  1-cycle pulse per decoded 10-bit symbol from RX
comma  input  1  current symbol is a comma (qualified by symValid)
err  input  1  current symbol invalid or wrong RD (qualified by symValid)
rxResetN  output  1  active-low reset driven to the RX block
linkUp  output  1  link locked (LOCKED or DEGRADED)
state  output  3  current state encoding
errTotal  output  ERRCNT_W  saturating count of symbol errors while acquiring/locked
realignCount  output  8  saturating count of REALIGN entries

Behaviour:
- Reset (resetN=0 at clk edge):
  - state=DISABLED, rxResetN=0, linkUp=0, errTotal=0, realignCount=0.
  - All internal counters (timer, commaCnt, errLevel, goodCnt) =0.
- All outputs are registered; state transitions take effect on the clk edge after the causing input.
- Encoding: DISABLED=0, HUNT=1, ACQ=2, LOCKED=3, DEGRADED=4, REALIGN=5; codes 6-7 go to DISABLED.
- Priority order: resetN, then enable=0, then REALIGN conditions, then lock/progress conditions.
- enable=0 in any state: DISABLED next cycle. No realignCount increment. Counters clear. errTotal held.
- Symbol rules:
  - A symbol counts only when symValid=1.
  - err=1 overrides comma=1 on the same symbol; the symbol is treated as an error, not a comma.
- DISABLED:
  - rxResetN=0, linkUp=0.
  - enable=1 goes to HUNT; timer=0.
- HUNT:
  - rxResetN=1; timer increments each cycle.
  - Good comma (comma&~err): ACQ, commaCnt=1.
  - Timer reaching HUNT_TIMEOUT-1: REALIGN.
  - Non-comma and error symbols are ignored; they are not counted in errTotal.
- ACQ:
  - Timer continues counting; it is not cleared on entry.
  - Error symbol: REALIGN; errTotal+1.
  - Good comma: commaCnt+1.
  - When commaCnt+1==LOCK_COMMAS: LOCKED, timer=0.
  - Good non-comma symbols are allowed and do not reset commaCnt.
  - Timeout: REALIGN.
- LOCKED:
  - linkUp=1; no timeout.
  - Error symbol: DEGRADED, errLevel=1, goodCnt=0, errTotal+1.
- DEGRADED:
  - linkUp=1.
  - Error symbol: errTotal+1, goodCnt=0, errLevel+1.
  - If errLevel+1==MAX_ERR: REALIGN.
  - Good symbol: goodCnt+1.
  - When goodCnt+1==GOOD_WIN: goodCnt=0, errLevel-1.
  - If errLevel reaches 0: LOCKED.
- REALIGN:
  - On entry, realignCount+1 (saturates at 255). rxResetN=0, linkUp=0.
  - Held for exactly REALIGN_CYC cycles, then HUNT with timer=0, commaCnt=0, errLevel=0.
  - symValid and flags are ignored.
- errTotal saturates at all-ones; it clears only on resetN.
- linkUp deasserts on the same edge that leaves LOCKED/DEGRADED.
- Synchronous reset asserted mid-REALIGN or mid-DEGRADED: full reset values on the next edge.

Test Plan:
1. Reset, enable=1, three good commas then data → DISABLED→HUNT (1 cycle) → ACQ → LOCKED after third comma; linkUp=1; rxResetN=1; errTotal=0.
2. From LOCKED, 1 error then 16 good symbols → DEGRADED with linkUp=1 → back to LOCKED on the 16th good symbol; errTotal=1; realignCount=0.
3. From LOCKED, 4 errors separated by ≤15 good symbols → REALIGN after 4th error; rxResetN low exactly 8 cycles; then HUNT; realignCount=1; errTotal=4.
4. enable=1 with no commas → REALIGN at cycle 1023 after HUNT entry; repeats periodically; realignCount increments each time and saturates at 255.
5. In ACQ after 2 good commas, symbol with comma=1,err=1 → REALIGN next edge; errTotal=1; commaCnt not advanced.
6. Deassert enable while in DEGRADED, and separately assert resetN=0 mid-REALIGN → DISABLED next edge with rxResetN=0, linkUp=0; errTotal held in the enable case, cleared in the reset case.
